// File: rtl/vec_acc.sv
// vec_acc: saturating accumulator that folds cfg_len partial sums from vec_mul
// into one result behind a valid/ready output register. Optional ReLU: VEC_ACC_RELU_EN.
module vec_acc #(
  parameter  int W_Y   = 18,
  parameter  int W_A   = 24,
  parameter  int N_MAX = 16,
  localparam int W_N   = $clog2(N_MAX + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [W_N-1:0] cfg_len,
  input  logic [W_Y-1:0] y_in,
  input  logic           y_valid,
  output logic           y_ready,
  output logic [W_A-1:0] acc_out,
  output logic           acc_sat,
  output logic           acc_valid,
  input  logic           acc_ready,
  output logic           drop_err
);

  typedef enum logic {ACC, FULL} state_t;

  localparam logic [W_A-1:0] ACC_MAX = {1'b0, {(W_A-1){1'b1}}};
  localparam logic [W_A-1:0] ACC_MIN = {1'b1, {(W_A-1){1'b0}}};

  state_t         state, next_state;
  logic [W_A-1:0] acc;
  logic           sat_q;
  logic [W_N-1:0] cnt;
  logic [W_N-1:0] len_q;

  logic                  accept;
  logic                  first;
  logic                  last;
  logic                  out_free;
  logic                  ovf;
  logic                  sat_new;
  logic [W_N-1:0]        len_clamp;
  logic [W_N-1:0]        len_eff;
  logic [W_N-1:0]        cnt_inc;
  logic signed [W_A:0]   sum_wide;
  logic [W_A-1:0]        sum_val;
  logic                  load_out;
  logic [W_A-1:0]        load_val;
  logic                  load_sat;

  function automatic logic [W_A-1:0] out_map(input logic [W_A-1:0] v);
`ifdef VEC_ACC_RELU_EN
    return v[W_A-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Datapath: one extra bit catches overflow; differing top bits mean it left range.
  always_comb begin
    accept    = y_valid && (state == ACC);
    first     = (cnt == '0);
    out_free  = !acc_valid || acc_ready;
    len_clamp = (cfg_len == '0)           ? W_N'(1)     :
                (cfg_len > W_N'(N_MAX))   ? W_N'(N_MAX) : cfg_len;
    len_eff   = first ? len_clamp : len_q;
    cnt_inc   = cnt + 1'b1;
    last      = (cnt_inc == len_eff);
    sum_wide  = (W_A+1)'($signed(acc)) + (W_A+1)'($signed(y_in));
    ovf       = 1'b0;
    if (first) begin
      sum_val = W_A'($signed(y_in));
    end else if (sum_wide[W_A] != sum_wide[W_A-1]) begin
      ovf     = 1'b1;
      sum_val = sum_wide[W_A] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_val = sum_wide[W_A-1:0];
    end
    sat_new = !first && (sat_q || ovf);
  end

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    y_ready    = 1'b0;
    load_out   = 1'b0;
    load_val   = acc;
    load_sat   = sat_q;
    unique case (state)
      ACC: begin
        y_ready = 1'b1;
        if (accept && last) begin
          if (out_free) begin
            load_out = 1'b1;
            load_val = sum_val;
            load_sat = sat_new;
          end else begin
            next_state = FULL;
          end
        end
      end
      FULL: begin
        if (acc_valid && acc_ready) begin
          load_out   = 1'b1;
          next_state = ACC;
        end
      end
      default: next_state = ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rstn) state <= ACC;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc       <= '0;
      sat_q     <= 1'b0;
      cnt       <= '0;
      len_q     <= '0;
      acc_out   <= '0;
      acc_sat   <= 1'b0;
      acc_valid <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      if (accept) begin
        acc   <= sum_val;
        sat_q <= sat_new;
        if (first) len_q <= len_clamp;
        cnt <= (last && out_free) ? '0 : cnt_inc;
      end
      if (state == FULL && load_out) cnt <= '0;

      if (load_out) begin
        acc_out   <= out_map(load_val);
        acc_sat   <= load_sat;
        acc_valid <= 1'b1;
      end else if (acc_ready) begin
        acc_valid <= 1'b0;
      end

      // vec_mul cannot stall, so a partial offered while busy is lost for good.
      if (y_valid && !y_ready) drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vec_acc.sv
// Directed bench for vec_acc: a W_A=24 instance plus a W_A=18 instance on the
// same stimulus, the latter used for the saturation corner cases.
module tb_vec_acc;

  logic               clk = 1'b0;
  logic               rstn;
  logic [4:0]         cfg_len;
  logic [17:0]        y_in;
  logic               y_valid;
  logic               acc_ready;

  logic               y_ready24, y_ready18;
  logic signed [23:0] acc_out24;
  logic signed [17:0] acc_out18;
  logic               acc_sat24, acc_sat18;
  logic               acc_valid24, acc_valid18;
  logic               drop_err24, drop_err18;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vec_acc #(.W_Y(18), .W_A(24), .N_MAX(16)) u_dut24 (
    .clk(clk), .rstn(rstn), .cfg_len(cfg_len), .y_in(y_in), .y_valid(y_valid),
    .y_ready(y_ready24), .acc_out(acc_out24), .acc_sat(acc_sat24),
    .acc_valid(acc_valid24), .acc_ready(acc_ready), .drop_err(drop_err24)
  );

  vec_acc #(.W_Y(18), .W_A(18), .N_MAX(16)) u_dut18 (
    .clk(clk), .rstn(rstn), .cfg_len(cfg_len), .y_in(y_in), .y_valid(y_valid),
    .y_ready(y_ready18), .acc_out(acc_out18), .acc_sat(acc_sat18),
    .acc_valid(acc_valid18), .acc_ready(acc_ready), .drop_err(drop_err18)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    y_in    = 18'(v);
    y_valid = 1'b1;
    tick();
  endtask

  task automatic idle();
    y_valid = 1'b0;
    tick();
  endtask

  initial begin
    logic signed [31:0] relu_exp;

    rstn = 1'b0; cfg_len = '0; y_in = '0; y_valid = 1'b0; acc_ready = 1'b1;
    tick();
    check("rst_acc_out",   acc_out24,   0);
    check("rst_acc_valid", acc_valid24, 0);
    check("rst_acc_sat",   acc_sat24,   0);
    check("rst_drop_err",  drop_err24,  0);
    check("rst_y_ready",   y_ready24,   1);
    rstn = 1'b1;

    // Basic: four partials of 75
    cfg_len = 5'd4;
    push(75); push(75); push(75);
    check("basic_not_yet", acc_valid24, 0);
    push(75);
    check("basic_valid", acc_valid24, 1);
    check("basic_out",   acc_out24,   300);
    check("basic_sat",   acc_sat24,   0);
    idle();
    check("basic_drop_valid", acc_valid24, 0);

    // cfg_len=1: back-to-back results
    cfg_len = 5'd1;
    push(5);  check("len1_a", acc_out24, 5);  check("len1_a_v", acc_valid24, 1);
    push(-7); check("len1_b", acc_out24, -7); check("len1_b_v", acc_valid24, 1);
    push(9);  check("len1_c", acc_out24, 9);  check("len1_c_v", acc_valid24, 1);
    idle();

    // cfg_len=0 behaves as 1
    cfg_len = 5'd0;
    push(11); check("len0_a", acc_out24, 11); check("len0_a_v", acc_valid24, 1);
    push(-3); check("len0_b", acc_out24, -3); check("len0_b_v", acc_valid24, 1);
    idle();

    // cfg_len above N_MAX clamps to 16
    cfg_len = 5'd20;
    for (int i = 0; i < 15; i++) push(1);
    check("clamp_not_yet", acc_valid24, 0);
    push(1);
    check("clamp_out",   acc_out24,   16);
    check("clamp_valid", acc_valid24, 1);
    idle();

    // Saturation: 3 x 100000 and 3 x -100000
    cfg_len = 5'd3;
    push(100000); push(100000); push(100000);
    check("sat24_pos_out", acc_out24, 300000);
    check("sat24_pos_sat", acc_sat24, 0);
    check("sat18_pos_out", acc_out18, 131071);
    check("sat18_pos_sat", acc_sat18, 1);
    push(-100000); push(-100000); push(-100000);
    check("sat24_neg_out", acc_out24, -300000);
    check("sat24_neg_sat", acc_sat24, 0);
    check("sat18_neg_out", acc_out18, -131072);
    check("sat18_neg_sat", acc_sat18, 1);
    idle();
    check("sat18_valid_drop", acc_valid18, 0);

    // Backpressure: hold 3, fill FULL with 7, drop 5
    acc_ready = 1'b0;
    cfg_len   = 5'd2;
    push(1); push(2);
    check("bp_first_out",   acc_out24,   3);
    check("bp_first_valid", acc_valid24, 1);
    push(3); push(4);
    check("bp_full_y_ready", y_ready24, 0);
    check("bp_hold_out",     acc_out24, 3);
    push(5);
    check("bp_drop_err",   drop_err24, 1);
    check("bp_still_held", acc_out24,  3);
    y_valid   = 1'b0;
    acc_ready = 1'b1;
    check("bp_out_3_offered", acc_out24, 3);
    tick();
    check("bp_out_7",       acc_out24,   7);
    check("bp_out_7_valid", acc_valid24, 1);
    check("bp_ready_back",  y_ready24,   1);
    tick();
    check("bp_valid_drop",   acc_valid24, 0);
    check("bp_drop_sticky",  drop_err24,  1);

    // Reset mid-group discards partials and clears sticky flag
    cfg_len = 5'd4;
    push(10); push(20);
    y_valid = 1'b0;
    rstn    = 1'b0;
    tick();
    check("mid_rst_out",   acc_out24,   0);
    check("mid_rst_valid", acc_valid24, 0);
    check("mid_rst_drop",  drop_err24,  0);
    check("mid_rst_ready", y_ready24,   1);
    rstn    = 1'b1;
    cfg_len = 5'd2;
    push(1);
    check("post_rst_not_yet", acc_valid24, 0);
    check("post_rst_out0",    acc_out24,   0);
    push(1);
    check("post_rst_out",   acc_out24,   2);
    check("post_rst_valid", acc_valid24, 1);
    idle();

    // ReLU option
`ifdef VEC_ACC_RELU_EN
    relu_exp = 0;
`else
    relu_exp = -30;
`endif
    push(-50); push(20);
    check("relu_out", acc_out24, relu_exp);
    check("relu_sat", acc_sat24, 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vec_acc.md
Name: vec_acc

Overview:
- Downstream stage of the vec_mul dot-product unit: consumes its per-cycle partial sums (y, valid) and accumulates cfg_len consecutive partials into one long-vector dot product.
- Delivers each completed result through a valid/ready output register to the writeback/requantize stage.
- Saturating accumulation with a per-result saturation flag; sticky error flag for partials dropped under backpressure.

Parameters:
- W_Y, 18, width of signed partial input (W_X + W_K + clog2(C) for C=4, 8b x 8b).
- W_A, 24, width of signed accumulator and result.
- N_MAX, 16, maximum partials per result; count register width W_N = $clog2(N_MAX+1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- cfg_len  in  W_N  partials per result. Sampled when the first partial of a group is accepted. 0 is treated as 1; values > N_MAX are clamped to N_MAX.
- y_in  in  W_Y  signed partial sum from vec_mul.
- y_valid  in  1  y_in valid this cycle.
- y_ready  out  1  accumulator can take a partial this cycle.
- acc_out  out  W_A  signed completed result.
- acc_sat  out  1  the result in acc_out saturated at least once during its accumulation.
- acc_valid  out  1  acc_out/acc_sat valid.
- acc_ready  in  1  consumer accepts the result.
- drop_err  out  1  sticky: a partial arrived while y_ready=0.

Behaviour:
- Reset (rstn=0 at posedge), applies even mid-group or with a result held:
  - acc, cnt, len_q, out register, acc_out, acc_sat, acc_valid, drop_err all go to 0.
  - State goes to ACC; y_ready=1 in the first cycle after reset.
  - Any partial group in progress is discarded.
- Accept: a partial is accepted on a posedge where y_valid & y_ready.
- State ACC (accumulating, cnt = partials taken so far, 0..len_q-1):
  - cnt==0 accept: len_q <= clamp(cfg_len); acc <= sext(y_in); sat_q <= 0; cnt <= 1.
  - cnt>0 accept: acc <= sat(acc + sext(y_in)); sat_q |= overflow; cnt++.
  - Sum is computed at W_A+1 bits. If it exceeds 2^(W_A-1)-1 it clamps to that value; below -2^(W_A-1) it clamps to -2^(W_A-1); either case sets sat_q.
  - Accept that completes the group (new cnt == len_q, including len_q=1):
    - Out register empty, or being emptied this cycle (acc_valid & acc_ready): the final sum and sat go directly into the out register, so acc_valid=1 the next cycle (1-cycle latency). cnt <= 0; stay in ACC.
    - Otherwise go to FULL, holding the final sum.
- State FULL:
  - y_ready=0.
  - On the first cycle the out register frees (acc_valid & acc_ready), acc/sat move into it; cnt <= 0; go to ACC.
  - y_ready returns to 1 the cycle after that transfer.
- y_ready = (state==ACC).
  - vec_mul has no backpressure, so y_valid while y_ready=0 discards the partial and sets drop_err (cleared only by reset).
- Output handshake:
  - acc_out, acc_sat, acc_valid are registered and stable while acc_valid & !acc_ready.
  - acc_valid drops the cycle after a handshake unless a new result loads the same cycle, which gives back-to-back results at full throughput.
- Simultaneous events in one cycle: handshake plus final accept, or handshake plus FULL transfer, both complete; no bubble, no loss.
- Throughput: one partial per cycle. Bubbles in y_valid are allowed anywhere in a group.

Optional Feature:
- Macro: VEC_ACC_RELU_EN.
- Defined: the value loaded into the out register is max(result, 0). acc_sat reflects the pre-ReLU accumulation.
- Undefined: the result passes signed and unchanged.
- The accumulator itself is identical in both builds.

Test Plan:
- Basic sum: cfg_len=4, four partials of 75 (vec_mul x=32'h03020107, k=32'h01030309), acc_ready=1 -> acc_out=300, acc_sat=0, acc_valid one cycle after the 4th accept.
- Length edges:
  - cfg_len=1, partials 5,-7,9 -> three results 5,-7,9, back-to-back acc_valid.
  - cfg_len=0 behaves identically to cfg_len=1.
- Saturation, W_A=24, cfg_len=3, partials 100000 each (sum 300000 < 8388607): no saturation, acc_out=300000, acc_sat=0.
  - With W_A=18: +131071, acc_sat=1.
  - Negative partials at W_A=18: -131072, acc_sat=1.
- Backpressure: acc_ready=0, cfg_len=2, partials 1,2,3,4,5 ->
  - First result 3 held.
  - Second group (3,4) completes; FULL; y_ready=0.
  - Partial 5 dropped; drop_err=1.
  - Raise acc_ready -> outputs 3 then 7 on consecutive cycles.
- Reset mid-group: cfg_len=4, two partials 10,20, rstn=0 one cycle, then cfg_len=2 with 1,1 -> acc_out=2; all outputs 0 during/after reset until the result.
- VEC_ACC_RELU_EN defined: cfg_len=2, partials -50,20 -> acc_out=0. Undefined -> acc_out=-30.
